// File: rtl/pkg_shift_add.sv
// pkg_shift_add: weight term type, greedy power-of-two decomposition and saturation limits
package pkg_shift_add;

    typedef struct packed {
        logic       en;
        logic       neg;
        logic [7:0] sh;
    } term_t;

    function automatic int near_sh(longint m);
        int s = 0;
        while ((64'sd1 <<< (s + 1)) <= m) s++;
        return (m - (64'sd1 <<< s) > (64'sd2 <<< s) - m) ? s + 1 : s;
    endfunction

    function automatic longint peel(longint r);
        longint m = r < 0 ? -r : r;
        return r == 0 ? 64'sd0 : r < 0 ? r + (64'sd1 <<< near_sh(m)) : r - (64'sd1 <<< near_sh(m));
    endfunction

    function automatic longint residual(longint w, int n);
        longint r = w;
        for (int i = 0; i < n; i++) r = peel(r);
        return r;
    endfunction

    function automatic term_t term_at(longint w, int idx);
        longint r = residual(w, idx);
        longint m = r < 0 ? -r : r;
        term_t t = '0;
        if (r != 0) t = '{en: 1'b1, neg: r < 0, sh: 8'(near_sh(m))};
        return t;
    endfunction

    function automatic longint sat_hi(int obits);
        return (64'sd1 <<< (obits - 1)) - 1;
    endfunction

    function automatic longint sat_lo(int obits);
        return -(64'sd1 <<< (obits - 1));
    endfunction

endpackage

// File: rtl/shift_add_lane.sv
// shift_add_lane: one channel of x*W with rounding and saturation, 3 registered stages
module shift_add_lane
    import pkg_shift_add::*;
#(
    parameter int BITS  = 17,
    parameter int NFRAC = 8,
    parameter int OBITS = 17,
    parameter int DEPTH = 3,
    parameter int ROUND = 1,
    parameter logic signed [BITS-1:0] W = BITS'(1 << NFRAC)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    adv_i,
    input  logic signed [BITS-1:0]  x_i,
    output logic signed [OBITS-1:0] y_o,
    output logic                    sat_o
);
    localparam int SW = 2 * BITS + 2;
    localparam bit USE_SA = residual(longint'(W), DEPTH) == 0;
    localparam logic signed [SW-1:0] HI = SW'(sat_hi(OBITS));
    localparam logic signed [SW-1:0] LO = SW'(sat_lo(OBITS));
    localparam logic signed [SW-1:0] RND = (ROUND != 0 && NFRAC > 0) ? SW'(64'sd1 <<< (NFRAC - 1)) : '0;

    logic [DEPTH-1:0][SW-1:0] term_d, term_q;
    logic signed [SW-1:0] xs, sum_d, sum_q, shf;
    logic signed [OBITS-1:0] y_d, y_q;
    logic sat_d, sat_q;

    assign xs = SW'(x_i);

    // exact weights become shifted copies of x; the rest fall back to one product in slot 0
    for (genvar d = 0; d < DEPTH; d++) begin : g_term
        if (!USE_SA) begin : g_mul
            assign term_d[d] = d == 0 ? xs * SW'(W) : '0;
        end else begin : g_sa
            localparam term_t T = term_at(longint'(W), d);
            assign term_d[d] = !T.en ? '0 : T.neg ? -(xs <<< T.sh) : xs <<< T.sh;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < DEPTH; i++) sum_d = sum_d + $signed(term_q[i]);
        shf = (sum_q + RND) >>> NFRAC;
        sat_d = shf > HI || shf < LO;
        y_d = shf > HI ? OBITS'(HI) : shf < LO ? OBITS'(LO) : shf[OBITS-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            term_q <= '0;
            sum_q  <= '0;
            y_q    <= '0;
            sat_q  <= 1'b0;
        end else if (adv_i) begin
            term_q <= term_d;
            sum_q  <= sum_d;
            y_q    <= y_d;
            sat_q  <= sat_d;
        end
    end

    assign y_o   = y_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/shift_add_pipe.sv
// shift_add_pipe: NCH constant-weight scaling lanes behind one valid/ready 3-stage pipeline
module shift_add_pipe
    import pkg_shift_add::*;
#(
    parameter int NCH   = 4,
    parameter int BITS  = 17,
    parameter int NFRAC = 8,
    parameter int OBITS = 17,
    parameter int DEPTH = 3,
    parameter int ROUND = 1,
    parameter logic signed [NCH*BITS-1:0] WEIGHTS = {NCH{BITS'(1 << NFRAC)}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*BITS-1:0]   data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*OBITS-1:0]  data_out,
    output logic [NCH-1:0]        sat_flag
);
    logic [2:0] vld_q;
    logic adv;

    // the whole pipe moves as one; a bubble in any stage is carried, never squeezed out
    assign adv       = !vld_q[2] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_q <= '0;
        else if (adv) vld_q <= {vld_q[1:0], in_valid};
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        shift_add_lane #(
            .BITS (BITS),
            .NFRAC(NFRAC),
            .OBITS(OBITS),
            .DEPTH(DEPTH),
            .ROUND(ROUND),
            .W    (WEIGHTS[k*BITS +: BITS])
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .adv_i  (adv),
            .x_i    (data_in[k*BITS +: BITS]),
            .y_o    (data_out[k*OBITS +: OBITS]),
            .sat_o  (sat_flag[k])
        );
    end

endmodule
